apb_master: RTL and testbench

APB_MASTER -- requirements
Module: apb_master

---
 rtl/apb_mst_pkg.sv | 19 +
 rtl/apb_mst_tmo.sv | 29 ++
 rtl/apb_master.sv | 136 +++++++++++++
 tb/tb_apb_master.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/apb_mst_pkg.sv
// Shared types and default sizing for the APB master.
package apb_mst_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

    localparam int ADDR_W_DEF  = 4;
    localparam int DATA_W_DEF  = 8;
    localparam int TMO_CYC_DEF = 16;

    // Counter width able to hold the value n itself.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/apb_mst_tmo.sv
// ACCESS wait-state watchdog: counts consecutive stalled cycles, flags the one that hits TMO_CYC.
module apb_mst_tmo
    import apb_mst_pkg::*;
#(
    parameter int TMO_CYC = TMO_CYC_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    localparam int CW = cnt_width(TMO_CYC);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + 1'b1;
        end
    end

    // The stalled cycle that would make the count reach TMO_CYC is the expiring one.
    assign expired = inc && (cnt == CW'(TMO_CYC - 1));

endmodule

// File: rtl/apb_master.sv
// Command-to-APB bridge with registered APB outputs and one-cycle response pulse.
// Optional ACCESS timeout enabled by defining APB_MST_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | no transfer, ready for a command
// SETUP  | PSEL=1 PENABLE=0, address phase
// ACCESS | PSEL=1 PENABLE=1, waiting for PREADY
module apb_master
    import apb_mst_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TMO_CYC = TMO_CYC_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY
);

    apb_state_t state;
    logic       accept;
    logic       done;

    if (TMO_CYC < 1) begin : g_bad_tmo
        $error("apb_master: TMO_CYC must be at least 1");
    end

    assign done      = (state == ACCESS) && PREADY;
    assign cmd_ready = !rst && ((state == IDLE) || done);
    assign accept    = cmd_valid && cmd_ready;

`ifdef APB_MST_TIMEOUT_EN
    logic tmo_expired;
    logic rsp_err_q;

    apb_mst_tmo #(
        .TMO_CYC (TMO_CYC)
    ) u_tmo (
        .clk     (clk),
        .rst     (rst),
        .clr     (accept),
        .inc     ((state == ACCESS) && !PREADY),
        .expired (tmo_expired)
    );

    assign rsp_err = rsp_err_q;
`else
    assign rsp_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
`ifdef APB_MST_TIMEOUT_EN
            rsp_err_q <= 1'b0;
`endif
        end else begin
            rsp_valid <= 1'b0;
`ifdef APB_MST_TIMEOUT_EN
            rsp_err_q <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (accept) begin
                        PWRITE  <= cmd_write;
                        PADDR   <= cmd_addr;
                        PWDATA  <= cmd_wdata;
                        PSEL    <= 1'b1;
                        PENABLE <= 1'b0;
                        state   <= SETUP;
                    end
                end
                SETUP: begin
                    PENABLE <= 1'b1;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    if (PREADY) begin
                        rsp_valid <= 1'b1;
                        if (!PWRITE) begin
                            rsp_rdata <= PRDATA;
                        end
                        // A command accepted on the completing cycle chains straight into SETUP.
                        if (accept) begin
                            PWRITE  <= cmd_write;
                            PADDR   <= cmd_addr;
                            PWDATA  <= cmd_wdata;
                            PENABLE <= 1'b0;
                            state   <= SETUP;
                        end else begin
                            PSEL    <= 1'b0;
                            PENABLE <= 1'b0;
                            state   <= IDLE;
                        end
                    end
`ifdef APB_MST_TIMEOUT_EN
                    else if (tmo_expired) begin
                        PSEL      <= 1'b0;
                        PENABLE   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err_q <= 1'b1;
                        state     <= IDLE;
                    end
`endif
                end
                default: begin
                    PSEL    <= 1'b0;
                    PENABLE <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master with a small memory-backed APB completer.
module tb_apb_master;

    localparam int AW  = 4;
    localparam int DW  = 8;
    localparam int TMO = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          PSEL, PENABLE, PWRITE;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA;
    logic [DW-1:0] PRDATA;
    logic          PREADY;

    always #5 clk = ~clk;

    apb_master #(.ADDR_W(AW), .DATA_W(DW), .TMO_CYC(TMO)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY)
    );

    // Completer: PREADY after wait_states stalled ACCESS cycles, memory behind it.
    logic [DW-1:0] mem [16];
    int wait_states = 0;
    bit stuck = 1'b0;
    int wcnt = 0;

    assign PREADY = !stuck && PSEL && PENABLE && (wcnt >= wait_states);
    assign PRDATA = PREADY ? mem[PADDR] : 8'hEE;

    always @(posedge clk) begin
        if (PSEL && PENABLE && !PREADY) wcnt <= wcnt + 1;
        else wcnt <= 0;
        if (PSEL && PENABLE && PREADY && PWRITE) mem[PADDR] <= PWDATA;
    end

    int checks = 0;
    int failures = 0;
    logic [DW-1:0] last_rdata = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            waits;
        logic [DW-1:0] exp_rdata;
        bit            noise;
    } vec_t;

    vec_t vecs[6];

    task automatic do_txn(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                          input int waits, input logic [DW-1:0] exp_rdata, input bit noise);
        int psel_n = 0;
        int pen_n = 0;
        bit bad = 1'b0;
        bit seen = 1'b0;
        wait_states = waits;
        @(negedge clk);
        chk("ready_in_idle", {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (rsp_valid) begin
                seen = 1'b1;
                break;
            end
            if (PSEL) psel_n++;
            if (PENABLE) pen_n++;
            if (PSEL && (PADDR !== addr || PWRITE !== wr || (wr && PWDATA !== wdata))) bad = 1'b1;
            // Commands offered while not ready must be ignored.
            if (noise) begin
                if (cmd_ready) begin
                    cmd_valid = 1'b0;
                end else begin
                    cmd_valid = 1'b1;
                    cmd_write = ~wr;
                    cmd_addr  = addr ^ 4'hF;
                    cmd_wdata = 8'($urandom);
                end
            end
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        chk("rsp_seen", {31'd0, seen}, 32'd1);
        chk("psel_cycles", psel_n, 2 + waits);
        chk("penable_cycles", pen_n, 1 + waits);
        chk("payload_stable", {31'd0, bad}, 32'd0);
        chk("psel_low_at_rsp", {31'd0, PSEL}, 32'd0);
        chk("rsp_err", {31'd0, rsp_err}, 32'd0);
        if (!wr) last_rdata = exp_rdata;
        chk("rsp_rdata", {24'd0, rsp_rdata}, {24'd0, last_rdata});
        @(negedge clk);
        chk("rsp_one_cycle", {31'd0, rsp_valid}, 32'd0);
    endtask

    task automatic start_stuck();
        stuck = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'd4; cmd_wdata = 8'h00;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, rsp_cnt, hi, drop, spacing_bad, last_cyc, access_n;
        bit acc, seen;

        vecs[0] = '{1'b1, 4'd3, 8'h09, 0, 8'h00, 1'b0};
        vecs[1] = '{1'b1, 4'd5, 8'h0B, 0, 8'h00, 1'b0};
        vecs[2] = '{1'b0, 4'd5, 8'h00, 3, 8'h0B, 1'b0};
        vecs[3] = '{1'b1, 4'd7, 8'hA5, 1, 8'h00, 1'b1};
        vecs[4] = '{1'b0, 4'd7, 8'h00, 0, 8'hA5, 1'b0};
        vecs[5] = '{1'b0, 4'd3, 8'h00, 2, 8'h09, 1'b1};

        repeat (2) @(negedge clk);
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        chk("rst_outputs", {26'd0, PSEL, PENABLE, PWRITE, rsp_valid, rsp_err, 1'b0},
            32'd0);
        chk("rst_data", {12'd0, PADDR, PWDATA, rsp_rdata}, 32'd0);
        rst = 1'b0;

        foreach (vecs[i])
            do_txn(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].waits,
                   vecs[i].exp_rdata, vecs[i].noise);

        // Back-to-back writes, cmd_valid held high.
        wait_states = 0;
        rsp_cnt = 0; hi = 0; drop = 0; spacing_bad = 0; last_cyc = 0; k = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'd0; cmd_wdata = 8'd6;
        for (int cyc = 0; cyc < 200; cyc++) begin
            acc = cmd_ready && cmd_valid;
            @(negedge clk);
            if (rsp_valid) begin
                rsp_cnt++;
                if (rsp_cnt > 1 && cyc - last_cyc != 2) spacing_bad++;
                last_cyc = cyc;
            end
            if (rsp_cnt < 16 && !PSEL) drop++;
            if (PSEL) hi++;
            if (acc) begin
                k++;
                if (k < 16) begin
                    cmd_addr  = 4'(k);
                    cmd_wdata = 8'(k + 6);
                end else begin
                    cmd_valid = 1'b0;
                end
            end
            if (rsp_cnt == 16) break;
        end
        cmd_valid = 1'b0;
        chk("b2b_rsp_count", rsp_cnt, 16);
        chk("b2b_psel_drops", drop, 0);
        chk("b2b_psel_cycles", hi, 32);
        chk("b2b_spacing", spacing_bad, 0);

        for (int a = 0; a < 16; a++)
            do_txn(1'b0, 4'(a), 8'h00, a % 3, 8'(a + 6), 1'b0);

        // Completer never answers.
        start_stuck();
        access_n = 0; seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (rsp_valid) begin
                seen = 1'b1;
                break;
            end
            if (PSEL && PENABLE) access_n++;
            @(negedge clk);
        end
`ifdef APB_MST_TIMEOUT_EN
        chk("tmo_rsp_seen", {31'd0, seen}, 32'd1);
        chk("tmo_access_cycles", access_n, TMO);
        chk("tmo_rsp_err", {31'd0, rsp_err}, 32'd1);
        chk("tmo_psel", {30'd0, PSEL, PENABLE}, 32'd0);
        chk("tmo_rdata", {24'd0, rsp_rdata}, {24'd0, last_rdata});
        start_stuck();
        repeat (3) @(negedge clk);
`else
        chk("stall_no_rsp", {31'd0, seen}, 32'd0);
        chk("stall_access_cycles", access_n, 40);
`endif
        chk("stall_in_access", {30'd0, PSEL, PENABLE}, 32'd3);

        // Reset while stalled in ACCESS.
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_psel", {30'd0, PSEL, PENABLE}, 32'd0);
        chk("rst_mid_rsp", {31'd0, rsp_valid}, 32'd0);
        chk("rst_mid_ready", {31'd0, cmd_ready}, 32'd0);
        rst = 1'b0;
        stuck = 1'b0;
        last_rdata = '0;
        @(negedge clk);
        chk("post_rst_rsp", {31'd0, rsp_valid}, 32'd0);
        chk("post_rst_ready", {31'd0, cmd_ready}, 32'd1);
        chk("post_rst_rdata", {24'd0, rsp_rdata}, 32'd0);

        do_txn(1'b0, 4'd9, 8'h00, 1, 8'd15, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
